senha_scanner: RTL
==================

SENHA_SCANNER -- requirements
Module: senha_scanner

Interface
REQ-001 Parameter: N_ENTRIES, 16, number of stored 8-bit passwords; power of two, 2..256.
REQ-002 Parameter: DEFAULT_SENHA, 8'h2A, value loaded into every entry at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears/initialises all state immediately.
REQ-005 ena_cnt  input  1  scan enable from the password controller; high while comparison in progress.
REQ-006 prog_we  input  1  write request for one password entry.
REQ-007 prog_addr  input  log2(N_ENTRIES)  entry index for write.
REQ-008 prog_data  input  8  password value for write.
REQ-009 out_mem  output  8  stored entry at current scan address, to controller comparator.
REQ-010 FC  output  1  end-of-count: last entry currently presented.
REQ-011 addr  output  log2(N_ENTRIES)  current scan address.
REQ-012 prog_ack  output  1  one-cycle pulse: write accepted.
REQ-013 prog_err  output  1  one-cycle pulse: write rejected (scan active).

Function
REQ-014 Two-state FSM: IDLE (ena_cnt low last cycle), SCAN (ena_cnt high last cycle); transition IDLE->SCAN when ena_cnt=1, SCAN->IDLE when ena_cnt=0.
REQ-015 out_mem SHALL be a combinational read of entry[addr]; zero-latency, valid in the same cycle addr changes.
REQ-016 In IDLE, addr SHALL be 0, so entry 0 is presented on the first cycle the controller enables scanning.
REQ-017 Each rising edge with ena_cnt=1 SHALL increment addr by 1, modulo N_ENTRIES.
REQ-018 Any edge with ena_cnt=0 SHALL return addr to 0, regardless of position (abort or match mid-scan).
REQ-019 FC SHALL be combinational: ena_cnt=1 AND addr=N_ENTRIES-1; FC=0 whenever ena_cnt=0.
REQ-020 If ena_cnt remains high past the last entry, addr wraps to 0 and FC deasserts; no error flagged.
REQ-021 Write accepted only when FSM in IDLE and ena_cnt=0: entry[prog_addr]<=prog_data at the edge, prog_ack=1 next cycle.
REQ-022 prog_we while in SCAN or with ena_cnt=1: no write, prog_err=1 for exactly one cycle next cycle.
REQ-023 prog_we held high for k cycles in IDLE SHALL produce k writes and k ack pulses (no internal buffering).
REQ-024 A write to entry currently at addr (IDLE, addr=0) SHALL appear on out_mem the cycle after the write edge.
REQ-025 prog_ack and prog_err SHALL never be high in the same cycle.

Reset
REQ-026 On reset: FSM=IDLE, addr=0, all entries=DEFAULT_SENHA, prog_ack=0, prog_err=0; hence out_mem=DEFAULT_SENHA, FC=0.
REQ-027 Reset asserted mid-scan or mid-write SHALL discard the operation; no partial entry update.

Structure
REQ-028 Shared package holds N_ENTRIES default, address width function/constant, data width 8, DEFAULT_SENHA, FSM state encoding.
REQ-029 Storage SHALL be a sub-module senha_regfile (one write port, one combinational read port, async reset to DEFAULT_SENHA); FSM, address counter and handshake stay in senha_scanner.

Verification
REQ-030 Reset then ena_cnt=0 -> addr=0, out_mem=8'h2A, FC=0, prog_ack=prog_err=0.
REQ-031 Write 8'h11 to entry 5 in IDLE -> prog_ack pulse 1 cycle; later scan shows out_mem=8'h11 when addr=5.
REQ-032 ena_cnt high 16 cycles -> addr 0..15 on consecutive cycles, FC=1 only at addr=15; 17th cycle addr=0, FC=0.
REQ-033 ena_cnt high 3 cycles then low -> addr returns to 0 next edge; new scan restarts at entry 0.
REQ-034 prog_we with ena_cnt=1 at addr=7 -> prog_err pulse, entry unchanged, scan continues to addr=8.
REQ-035 Reset asserted while addr=9 in SCAN -> immediate addr=0, all entries back to 8'h2A, FC=0.

Source files
------------

// File: rtl/senha_scanner_pkg.sv
// Shared definitions for the password scanner: sizes, reset value and FSM states.
package senha_scanner_pkg;

    localparam int              N_ENTRIES_DEF     = 16;
    localparam int              DATA_W            = 8;
    localparam logic [DATA_W-1:0] DEFAULT_SENHA_DEF = 8'h2A;

    // Address width for a power-of-two entry count; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // IDLE: scan enable was low last cycle. SCAN: scan enable was high last cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/senha_regfile.sv
// Password storage: one synchronous write port, one combinational read port,
// every entry restored to the default password on reset.
module senha_regfile
    import senha_scanner_pkg::*;
#(
    parameter int                N_ENTRIES     = N_ENTRIES_DEF,
    parameter logic [DATA_W-1:0] DEFAULT_SENHA = DEFAULT_SENHA_DEF,
    localparam int               AW            = addr_width(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N_ENTRIES];

    // Entry storage; reset reloads the default password into every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= DEFAULT_SENHA;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read so the comparator sees the entry in the same cycle addr moves.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/senha_scanner.sv
// Password scanner: walks the stored passwords while the controller enables
// scanning, and accepts programming writes only while idle.
module senha_scanner
    import senha_scanner_pkg::*;
#(
    parameter int                N_ENTRIES     = N_ENTRIES_DEF,
    parameter logic [DATA_W-1:0] DEFAULT_SENHA = DEFAULT_SENHA_DEF,
    localparam int               AW            = addr_width(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena_cnt,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_mem,
    output logic              FC,
    output logic [AW-1:0]     addr,
    output logic              prog_ack,
    output logic              prog_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

    state_t state;
    logic   wr_accept;
    logic   wr_reject;

    // A write is only safe when no scan was running last cycle and none is starting now.
    always_comb begin
        wr_accept = prog_we && (state == ST_IDLE) && !ena_cnt;
        wr_reject = prog_we && !wr_accept;
    end

    // FSM, scan address counter and registered write handshake pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            prog_ack <= 1'b0;
            prog_err <= 1'b0;
        end else begin
            state    <= ena_cnt ? ST_SCAN : ST_IDLE;
            // Power-of-two depth lets the counter wrap naturally past the last entry.
            addr     <= ena_cnt ? addr + 1'b1 : '0;
            prog_ack <= wr_accept;
            prog_err <= wr_reject;
        end
    end

    // End-of-count only while actively scanning the last entry.
    always_comb begin
        FC = ena_cnt && (addr == LAST_ADDR);
    end

    senha_regfile #(
        .N_ENTRIES     (N_ENTRIES),
        .DEFAULT_SENHA (DEFAULT_SENHA)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (addr),
        .rdata (out_mem)
    );

endmodule
